// File: rtl/conv3x3_stream_ctrl.sv
// Streaming 3x3 convolution: two line buffers plus per-row shift registers
// build the window; a four-stage MAC pipeline with a global output stall.
module conv3x3_stream_ctrl #(
  parameter int DATA_W    = 16,
  parameter int IMG_W_MAX = 64,
  parameter int SHIFT     = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [15:0]         img_w,
  input  logic [15:0]         img_h,
  input  logic                stride2,
  input  logic [9*DATA_W-1:0] kernel,
  input  logic [DATA_W-1:0]   in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [DATA_W-1:0]   out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_last,
  output logic                busy,
  output logic                done,
  output logic                cfg_err
);

  localparam int PROD_W = 2*DATA_W;
  localparam int ACC_W  = 2*DATA_W + 4;
  localparam int LB_AW  = (IMG_W_MAX > 1) ? $clog2(IMG_W_MAX) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  function automatic logic [DATA_W-1:0] sat_fn(input logic signed [ACC_W-1:0] v);
    logic signed [ACC_W-1:0] hi;
    logic signed [ACC_W-1:0] lo;
    hi = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    lo = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
    if (v > hi) begin
      sat_fn = {1'b0, {(DATA_W-1){1'b1}}};
    end else if (v < lo) begin
      sat_fn = {1'b1, {(DATA_W-1){1'b0}}};
    end else begin
      sat_fn = v[DATA_W-1:0];
    end
  endfunction

  state_t state_r;
  state_t state_nx_s;

  logic [15:0] img_w_r;
  logic [15:0] img_h_r;
  logic        stride2_r;
  logic signed [DATA_W-1:0] kern_r [9];
  logic [31:0] total_r;
  logic [31:0] out_cnt_r;
  logic [15:0] col_r;
  logic [15:0] row_r;

  logic [DATA_W-1:0] lb0_r [IMG_W_MAX];
  logic [DATA_W-1:0] lb1_r [IMG_W_MAX];
  logic [DATA_W-1:0] sr0_r [2];
  logic [DATA_W-1:0] sr1_r [2];
  logic [DATA_W-1:0] sr2_r [2];
  logic [LB_AW-1:0]  col_idx_s;
  logic signed [DATA_W-1:0] win_s [9];

  logic                     v0_r;
  logic                     last0_r;
  logic signed [DATA_W-1:0] win_r [9];
  logic                     v1_r;
  logic                     last1_r;
  logic signed [PROD_W-1:0] prod_r [9];
  logic                     v2_r;
  logic                     last2_r;
  logic [DATA_W-1:0]        res2_r;
  logic signed [ACC_W-1:0]  sum_s;
  logic signed [ACC_W-1:0]  shr_s;

  logic              out_valid_r;
  logic [DATA_W-1:0] out_data_r;
  logic              out_last_r;
  logic              busy_r;
  logic              done_r;
  logic              cfg_err_r;
  logic              fin_seen_r;

  logic        stall_s;
  logic        accept_s;
  logic        emit_s;
  logic        last_px_s;
  logic        cfg_ok_s;
  logic        start_ok_s;
  logic        done_s;
  logic        cfg_err_s;
  logic        fin_hs_s;
  logic        pipe_empty_s;
  logic [15:0] ow_s;
  logic [15:0] oh_s;
  logic [31:0] total_s;

  assign stall_s   = out_valid_r && !out_ready;
  assign in_ready  = (state_r == ST_RUN) && !stall_s;
  assign accept_s  = in_valid && in_ready;
  assign fin_hs_s  = out_valid_r && out_ready && out_last_r;
  assign col_idx_s = col_r[LB_AW-1:0];

  assign last_px_s = (row_r == (img_h_r - 16'd1)) && (col_r == (img_w_r - 16'd1));
  // Stride 2 keeps windows whose top-left row/column is even.
  assign emit_s    = (row_r >= 16'd2) && (col_r >= 16'd2) &&
                     (!stride2_r || (!row_r[0] && !col_r[0]));

  assign cfg_ok_s  = (img_w >= 16'd3) && (img_w <= 16'(IMG_W_MAX)) && (img_h >= 16'd3);
  assign ow_s      = ((img_w - 16'd3) >> stride2) + 16'd1;
  assign oh_s      = ((img_h - 16'd3) >> stride2) + 16'd1;
  assign total_s   = 32'(ow_s) * 32'(oh_s);

  assign pipe_empty_s = !v0_r && !v1_r && !v2_r && (!out_valid_r || fin_hs_s);

  // Next-state and one-cycle event decode.
  always_comb begin
    state_nx_s = state_r;
    start_ok_s = 1'b0;
    done_s     = 1'b0;
    cfg_err_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          if (cfg_ok_s) begin
            start_ok_s = 1'b1;
            state_nx_s = ST_RUN;
          end else begin
            cfg_err_s  = 1'b1;
            state_nx_s = ST_IDLE;
          end
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (accept_s && last_px_s) begin
          state_nx_s = ST_DRAIN;
        end else begin
          state_nx_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if ((fin_seen_r || fin_hs_s) && pipe_empty_s) begin
          done_s     = 1'b1;
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_DRAIN;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // State register and frame-level status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      cfg_err_r  <= 1'b0;
      fin_seen_r <= 1'b0;
    end else begin
      state_r   <= state_nx_s;
      busy_r    <= (state_nx_s != ST_IDLE);
      done_r    <= done_s;
      cfg_err_r <= cfg_err_s;
      if (start_ok_s) begin
        fin_seen_r <= 1'b0;
      end else if (fin_hs_s) begin
        fin_seen_r <= 1'b1;
      end
    end
  end

  // Frame configuration latch plus raster and output counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      img_w_r   <= 16'd0;
      img_h_r   <= 16'd0;
      stride2_r <= 1'b0;
      total_r   <= 32'd0;
      out_cnt_r <= 32'd0;
      col_r     <= 16'd0;
      row_r     <= 16'd0;
      for (int k = 0; k < 9; k++) begin
        kern_r[k] <= {DATA_W{1'b0}};
      end
    end else if (start_ok_s) begin
      img_w_r   <= img_w;
      img_h_r   <= img_h;
      stride2_r <= stride2;
      total_r   <= total_s;
      out_cnt_r <= 32'd0;
      col_r     <= 16'd0;
      row_r     <= 16'd0;
      for (int k = 0; k < 9; k++) begin
        kern_r[k] <= kernel[k*DATA_W +: DATA_W];
      end
    end else if (accept_s) begin
      if (col_r == (img_w_r - 16'd1)) begin
        col_r <= 16'd0;
        row_r <= row_r + 16'd1;
      end else begin
        col_r <= col_r + 16'd1;
      end
      if (emit_s) begin
        out_cnt_r <= out_cnt_r + 32'd1;
      end
    end
  end

  // Line buffers shift rows upward per column; shift registers hold columns c-2, c-1.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      lb0_r[col_idx_s] <= lb1_r[col_idx_s];
      lb1_r[col_idx_s] <= in_data;
      sr0_r[1] <= sr0_r[0];
      sr0_r[0] <= lb0_r[col_idx_s];
      sr1_r[1] <= sr1_r[0];
      sr1_r[0] <= lb1_r[col_idx_s];
      sr2_r[1] <= sr2_r[0];
      sr2_r[0] <= in_data;
    end
  end

  // Window assembly: index 3*dy+dx, dy=0 is the oldest row.
  always_comb begin
    win_s[0] = sr0_r[1];
    win_s[1] = sr0_r[0];
    win_s[2] = lb0_r[col_idx_s];
    win_s[3] = sr1_r[1];
    win_s[4] = sr1_r[0];
    win_s[5] = lb1_r[col_idx_s];
    win_s[6] = sr2_r[1];
    win_s[7] = sr2_r[0];
    win_s[8] = in_data;
  end

  // Full-precision sum of the nine products.
  always_comb begin
    sum_s = {ACC_W{1'b0}};
    for (int k = 0; k < 9; k++) begin
      sum_s = sum_s + ACC_W'(prod_r[k]);
    end
  end

  assign shr_s = sum_s >>> SHIFT;

  // Window capture, products and sum/saturate stages, all frozen on stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      v0_r    <= 1'b0;
      last0_r <= 1'b0;
      v1_r    <= 1'b0;
      last1_r <= 1'b0;
      v2_r    <= 1'b0;
      last2_r <= 1'b0;
      res2_r  <= {DATA_W{1'b0}};
      for (int k = 0; k < 9; k++) begin
        win_r[k]  <= {DATA_W{1'b0}};
        prod_r[k] <= {PROD_W{1'b0}};
      end
    end else if (!stall_s) begin
      v0_r    <= accept_s && emit_s;
      last0_r <= accept_s && emit_s && (out_cnt_r == (total_r - 32'd1));
      if (accept_s) begin
        for (int k = 0; k < 9; k++) begin
          win_r[k] <= win_s[k];
        end
      end
      v1_r    <= v0_r;
      last1_r <= last0_r;
      for (int k = 0; k < 9; k++) begin
        prod_r[k] <= PROD_W'(win_r[k]) * PROD_W'(kern_r[k]);
      end
      v2_r    <= v1_r;
      last2_r <= last1_r;
      res2_r  <= sat_fn(shr_s);
    end
  end

  // Output register; holds its contents while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_data_r  <= {DATA_W{1'b0}};
      out_last_r  <= 1'b0;
    end else if (!stall_s) begin
      out_valid_r <= v2_r;
      out_data_r  <= res2_r;
      out_last_r  <= last2_r;
    end
  end

  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_last  = out_last_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign cfg_err   = cfg_err_r;

endmodule

// File: tb/tb_conv3x3_stream_ctrl.sv
// Bench for conv3x3_stream_ctrl: a frame-level convolution model feeds
// expectation queues for two instances (SHIFT=0 and SHIFT=4).
`timescale 1ns/1ps
module tb_conv3x3_stream_ctrl;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst, start, stride2, in_valid, out_ready;
  logic [15:0] img_w, img_h;
  logic [9*DW-1:0] kernel;
  logic [DW-1:0] in_data;
  logic in_ready0, out_valid0, out_last0, busy0, done0, cfg_err0;
  logic in_ready1, out_valid1, out_last1, busy1, done1, cfg_err1;
  logic [DW-1:0] out_data0, out_data1;

  always #5 clk = ~clk;

  conv3x3_stream_ctrl #(.DATA_W(DW), .IMG_W_MAX(64), .SHIFT(0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .img_w(img_w), .img_h(img_h),
    .stride2(stride2), .kernel(kernel), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready0), .out_data(out_data0), .out_valid(out_valid0),
    .out_ready(out_ready), .out_last(out_last0), .busy(busy0), .done(done0),
    .cfg_err(cfg_err0));

  conv3x3_stream_ctrl #(.DATA_W(DW), .IMG_W_MAX(64), .SHIFT(4)) dut1 (
    .clk(clk), .rst(rst), .start(start), .img_w(img_w), .img_h(img_h),
    .stride2(stride2), .kernel(kernel), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready1), .out_data(out_data1), .out_valid(out_valid1),
    .out_ready(out_ready), .out_last(out_last1), .busy(busy1), .done(done1),
    .cfg_err(cfg_err1));

  typedef struct packed { logic [DW-1:0] d; logic last; } exp_t;
  exp_t exp0[$];
  exp_t exp1[$];
  int got0[$];
  int got1[$];
  int ref_q[$];
  int pix [16][16];
  int kw [9];
  int checks = 0;
  int failures = 0;
  int rdy_mode = 0;
  int rc = 0;
  bit done_due = 1'b0;
  bit stall_prev = 1'b0;
  logic [DW-1:0] stall_data;

  task automatic chk(input string name, input longint act, input longint exp_v);
    checks++;
    if (act != exp_v) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  function automatic longint sat16(input longint v);
    if (v > 32767) return 32767;
    else if (v < -32768) return -32768;
    else return v;
  endfunction

  // Convolution straight from the definition, one entry per output position.
  task automatic build_expected(input int w, input int h, input bit s2);
    int s, ow, oh;
    longint acc;
    exp_t e;
    s  = s2 ? 2 : 1;
    ow = (w - 3) / s + 1;
    oh = (h - 3) / s + 1;
    for (int oy = 0; oy < oh; oy++) begin
      for (int ox = 0; ox < ow; ox++) begin
        acc = 0;
        for (int dy = 0; dy < 3; dy++)
          for (int dx = 0; dx < 3; dx++)
            acc += longint'(pix[oy*s+dy][ox*s+dx]) * longint'(kw[3*dy+dx]);
        e.last = (oy == oh-1) && (ox == ow-1);
        e.d = 16'(sat16(acc));
        exp0.push_back(e);
        e.d = 16'(sat16(acc >>> 4));
        exp1.push_back(e);
      end
    end
  endtask

  task automatic start_frame(input int w, input int h, input bit s2);
    for (int k = 0; k < 9; k++) kernel[k*DW +: DW] = 16'(kw[k]);
    img_w = 16'(w); img_h = 16'(h); stride2 = s2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    kernel = {9{16'h7abc}}; img_w = 16'd9; img_h = 16'd9; stride2 = ~s2;
  endtask

  task automatic drive_pixels(input int w, input int n);
    int idx, guard;
    bit acc;
    idx = 0; guard = 0;
    in_valid = 1'b1; in_data = 16'(pix[0][0]);
    while (idx < n && guard < 3000) begin
      @(negedge clk);
      acc = in_valid && in_ready0;
      @(posedge clk); #1;
      guard++;
      if (acc) begin
        idx++;
        if (idx < n) in_data = 16'(pix[idx / w][idx % w]);
      end
    end
    in_valid = 1'b0;
    chk("pixels_accepted", idx, n);
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (done0) seen = 1'b1;
    end
    chk("done_seen", seen, 1);
    chk("exp0_drained", exp0.size(), 0);
    chk("exp1_drained", exp1.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic run_frame(input int w, input int h, input bit s2);
    got0.delete(); got1.delete();
    start_frame(w, h, s2);
    drive_pixels(w, w*h);
    wait_done();
  endtask

  task automatic try_bad(input int w, input int h);
    img_w = 16'(w); img_h = 16'(h); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("cfg_err_pulse", cfg_err0, 1);
    chk("cfg_err_busy", busy0, 0);
    chk("cfg_err_in_ready", in_ready0, 0);
    @(negedge clk);
    chk("cfg_err_one_cycle", cfg_err0, 0);
    chk("cfg_err_idle", busy0, 0);
    @(posedge clk); #1;
  endtask

  // out_ready pattern: always 1, or alternating with a 10-cycle low hold.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (rdy_mode == 0) begin
        rc = 0;
        out_ready = 1'b1;
      end else begin
        rc++;
        out_ready = (rc >= 20 && rc < 30) ? 1'b0 : rc[0];
      end
    end
  end

  // Compare process: every output handshake, stall behaviour and done timing.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      done_due = 1'b0;
      stall_prev = 1'b0;
    end else begin
      if (done_due) begin
        chk("done_after_last", done0, 1);
        chk("busy_low_at_done", busy0, 0);
        done_due = 1'b0;
      end
      if (stall_prev) begin
        chk("stall_hold_valid", out_valid0, 1);
        chk("stall_hold_data", out_data0, stall_data);
      end
      stall_prev = 1'b0;
      if (out_valid0 && !out_ready) begin
        chk("stall_in_ready", in_ready0, 0);
        stall_prev = 1'b1;
        stall_data = out_data0;
      end
      if (out_valid0 && out_ready) begin
        if (exp0.size() == 0) chk("unexpected_out0", 1, 0);
        else begin
          e = exp0.pop_front();
          chk("out_data0", $signed(out_data0), $signed(e.d));
          chk("out_last0", out_last0, e.last);
          got0.push_back(int'($signed(out_data0)));
          if (e.last) done_due = 1'b1;
        end
      end
      if (out_valid1 && out_ready) begin
        if (exp1.size() == 0) chk("unexpected_out1", 1, 0);
        else begin
          e = exp1.pop_front();
          chk("out_data1", $signed(out_data1), $signed(e.d));
          chk("out_last1", out_last1, e.last);
          got1.push_back(int'($signed(out_data1)));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lit2 [4];
    lit2 = '{6, 8, 16, 18};
    rst = 1'b1; start = 1'b0; stride2 = 1'b0; in_valid = 1'b0; in_data = 16'd0;
    kernel = {9*DW{1'b0}}; img_w = 16'd0; img_h = 16'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready0, 0);
    chk("rst_out_valid", out_valid0, 0);
    chk("rst_out_data", out_data0, 0);
    chk("rst_out_last", out_last0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    chk("rst_cfg_err", cfg_err0, 0);
    @(posedge clk); #1;

    // All ones, stride 1: nine results of 9; SHIFT=4 instance gives 0.
    for (int r = 0; r < 16; r++) for (int c = 0; c < 16; c++) pix[r][c] = 1;
    for (int k = 0; k < 9; k++) kw[k] = 1;
    build_expected(5, 5, 1'b0);
    chk("model_ones_count", exp0.size(), 9);
    chk("model_ones_val", exp0[0].d, 9);
    chk("model_ones_shift4", exp1[0].d, 0);
    chk("model_ones_last", exp0[8].last, 1);
    run_frame(5, 5, 1'b0);
    chk("ones_results", got0.size(), 9);

    // Ramp with centre tap, stride 2.
    for (int r = 0; r < 5; r++) for (int c = 0; c < 5; c++) pix[r][c] = 5*r + c;
    for (int k = 0; k < 9; k++) kw[k] = (k == 4) ? 1 : 0;
    build_expected(5, 5, 1'b1);
    chk("model_ramp_count", exp0.size(), 4);
    run_frame(5, 5, 1'b1);
    chk("ramp_results", got0.size(), 4);
    if (got0.size() == 4)
      for (int i = 0; i < 4; i++) chk("ramp_value", got0[i], lit2[i]);

    // 6x4 frame, mixed signs; free-running then back-pressured.
    for (int r = 0; r < 4; r++) for (int c = 0; c < 6; c++) pix[r][c] = ((r*7 + c*3) % 11) - 5;
    kw = '{1, -2, 3, -1, 4, -1, 2, 0, -3};
    build_expected(6, 4, 1'b0);
    chk("model_6x4_count", exp0.size(), 8);
    run_frame(6, 4, 1'b0);
    ref_q = got0;
    rdy_mode = 1;
    build_expected(6, 4, 1'b0);
    run_frame(6, 4, 1'b0);
    rdy_mode = 0;
    chk("bp_results", got0.size(), ref_q.size());
    if (got0.size() == ref_q.size())
      for (int i = 0; i < ref_q.size(); i++) chk("bp_match", got0[i], ref_q[i]);

    // Saturation on the minimum 3x3 frame.
    for (int r = 0; r < 3; r++) for (int c = 0; c < 3; c++) pix[r][c] = 1000;
    for (int k = 0; k < 9; k++) kw[k] = 1000;
    build_expected(3, 3, 1'b0);
    chk("model_sat_pos", exp0[0].d, 16'h7fff);
    run_frame(3, 3, 1'b0);
    chk("sat_pos", got0.size() > 0 ? got0[0] : 0, 32767);
    for (int k = 0; k < 9; k++) kw[k] = -1000;
    build_expected(3, 3, 1'b0);
    run_frame(3, 3, 1'b0);
    chk("sat_neg", got0.size() > 0 ? got0[0] : 0, -32768);

    // Illegal configurations.
    try_bad(2, 5);
    try_bad(65, 5);
    try_bad(5, 2);

    // Reset while a result is in flight, then a clean all-ones frame.
    for (int r = 0; r < 5; r++) for (int c = 0; c < 5; c++) pix[r][c] = 3000 + 50*r + c;
    for (int k = 0; k < 9; k++) kw[k] = 1;
    start_frame(5, 5, 1'b0);
    drive_pixels(5, 13);
    rst = 1'b1;
    exp0.delete(); exp1.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_out_valid", out_valid0, 0);
    chk("mid_rst_out_data", out_data0, 0);
    chk("mid_rst_busy", busy0, 0);
    chk("mid_rst_in_ready", in_ready0, 0);
    @(posedge clk); #1;
    for (int r = 0; r < 5; r++) for (int c = 0; c < 5; c++) pix[r][c] = 1;
    build_expected(5, 5, 1'b0);
    run_frame(5, 5, 1'b0);
    chk("post_rst_results", got0.size(), 9);

    repeat (5) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
